// File: rtl/ex_stage_pkg.sv
// Shared definitions for the RV32IM execute stage: datapath width, ALU/branch/M-op codes,
// mul/div FSM state encoding and the operand-forwarding helper.
package ex_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    BRU_BEQ  = 3'd0,
    BRU_BNE  = 3'd1,
    BRU_JAL  = 3'd2,
    BRU_JALR = 3'd3,
    BRU_BLT  = 3'd4,
    BRU_BGE  = 3'd5,
    BRU_BLTU = 3'd6,
    BRU_BGEU = 3'd7
  } bru_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // EX/MEM has priority over MEM/WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_we,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] val;
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == idx)) begin
      val = ex_val;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == idx)) begin
      val = wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bus of the execute stage. The pipeline side uses the master modport,
// ex_stage uses the slave modport.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm_in;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic            alu_src;
  logic [3:0]      alu_op;
  logic            branch;
  logic [2:0]      bru_op;
  logic            md_en;
  logic [2:0]      md_op;
  logic            exmem_reg_write;
  logic            memwb_reg_write;
  logic [4:0]      exmem_rd;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] exmem_value;
  logic [XLEN-1:0] memwb_value;
  logic            flush_in;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] store_data;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            flush_out;
  logic            stall_out;

  modport master (
    output pc_in, rs1_data, rs2_data, imm_in, rs1_idx, rs2_idx, alu_src, alu_op,
           branch, bru_op, md_en, md_op, exmem_reg_write, memwb_reg_write,
           exmem_rd, memwb_rd, exmem_value, memwb_value, flush_in,
    input  alu_result, store_data, branch_taken, branch_target, flush_out, stall_out
  );

  modport slave (
    input  pc_in, rs1_data, rs2_data, imm_in, rs1_idx, rs2_idx, alu_src, alu_op,
           branch, bru_op, md_en, md_op, exmem_reg_write, memwb_reg_write,
           exmem_rd, memwb_rd, exmem_value, memwb_value, flush_in,
    output alu_result, store_data, branch_taken, branch_target, flush_out, stall_out
  );

endinterface

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M multiply/divide engine: 32 shift-add or restoring-division steps on
// operand magnitudes, sign fix-up on the DONE result, divide special cases resolved at start.
module muldiv_unit import ex_stage_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state_r;
  logic [4:0]  count_r;
  logic [63:0] acc_r;
  logic [31:0] opb_r;
  logic [2:0]  op_r;
  logic        neg_q_r;
  logic        neg_rem_r;

  logic        a_neg_s, b_neg_s, div_zero_s, div_ovf_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] mul_sum_s, rem_shift_s, div_diff_s;
  logic [63:0] step_s, prod_s;
  logic [31:0] quo_s, rem_s, result_s;

  // Start-time operand decode: signedness, magnitudes and divide special cases.
  always_comb begin
    a_neg_s    = a[31] & ((op == MD_MULH) | (op == MD_MULHSU) | (op == MD_DIV) | (op == MD_REM));
    b_neg_s    = b[31] & ((op == MD_MULH) | (op == MD_DIV) | (op == MD_REM));
    a_mag_s    = a_neg_s ? (32'd0 - a) : a;
    b_mag_s    = b_neg_s ? (32'd0 - b) : b;
    div_zero_s = op[2] & (b == 32'd0);
    div_ovf_s  = op[2] & ~op[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
    rem_shift_s = {acc_r[63:32], acc_r[31]};
    div_diff_s  = rem_shift_s - {1'b0, opb_r};
    if (op_r[2]) begin
      step_s = div_diff_s[32] ? {rem_shift_s[31:0], acc_r[30:0], 1'b0}
                              : {div_diff_s[31:0], acc_r[30:0], 1'b1};
    end else begin
      step_s = {mul_sum_s, acc_r[31:1]};
    end
  end

  // Sign fix-up and result selection from the finished accumulator.
  always_comb begin
    prod_s = neg_q_r ? (64'd0 - acc_r) : acc_r;
    quo_s  = neg_q_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
    rem_s  = neg_rem_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
    case (op_r)
      MD_MUL:                       result_s = prod_s[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_s = prod_s[63:32];
      MD_DIV, MD_DIVU:              result_s = quo_s;
      MD_REM, MD_REMU:              result_s = rem_s;
      default:                      result_s = 32'd0;
    endcase
  end

  // FSM, step counter and operand latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= MD_IDLE;
      count_r   <= 5'd0;
      acc_r     <= 64'd0;
      opb_r     <= 32'd0;
      op_r      <= 3'd0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (abort) begin
      state_r <= MD_IDLE;
      count_r <= 5'd0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            op_r    <= op;
            count_r <= 5'd0;
            if (div_zero_s) begin
              acc_r     <= {a, 32'hFFFF_FFFF};
              neg_q_r   <= 1'b0;
              neg_rem_r <= 1'b0;
              state_r   <= MD_DONE;
            end else if (div_ovf_s) begin
              acc_r     <= {32'd0, 32'h8000_0000};
              neg_q_r   <= 1'b0;
              neg_rem_r <= 1'b0;
              state_r   <= MD_DONE;
            end else begin
              acc_r     <= {32'd0, a_mag_s};
              opb_r     <= b_mag_s;
              neg_q_r   <= a_neg_s ^ b_neg_s;
              neg_rem_r <= a_neg_s;
              state_r   <= MD_BUSY;
            end
          end else begin
            state_r <= MD_IDLE;
          end
        end
        MD_BUSY: begin
          acc_r <= step_s;
          if (count_r == 5'd31) begin
            state_r <= MD_DONE;
          end else begin
            count_r <= count_r + 5'd1;
          end
        end
        MD_DONE: state_r <= MD_IDLE;
        default: state_r <= MD_IDLE;
      endcase
    end
  end

  assign busy   = (state_r == MD_BUSY);
  assign done   = (state_r == MD_DONE);
  assign result = result_s;

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: forwarding, ALU, branch unit and result mux. The mul/div engine
// and its stall are built only when EX_MULDIV_EN is defined.
module ex_stage import ex_stage_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] fwd_rs1_s, fwd_rs2_s, op_b_s, alu_s, link_s, target_s, base_result_s;
  logic            cond_s, is_link_s, stall_s;
  logic [XLEN-1:0] result_s;

  // Forwarding, ALU and branch resolution.
  always_comb begin
    fwd_rs1_s = fwd_operand(bus.rs1_idx, bus.rs1_data, bus.exmem_reg_write, bus.exmem_rd,
                            bus.exmem_value, bus.memwb_reg_write, bus.memwb_rd, bus.memwb_value);
    fwd_rs2_s = fwd_operand(bus.rs2_idx, bus.rs2_data, bus.exmem_reg_write, bus.exmem_rd,
                            bus.exmem_value, bus.memwb_reg_write, bus.memwb_rd, bus.memwb_value);
    op_b_s    = bus.alu_src ? bus.imm_in : fwd_rs2_s;

    case (bus.alu_op)
      ALU_ADD:   alu_s = fwd_rs1_s + op_b_s;
      ALU_SUB:   alu_s = fwd_rs1_s - op_b_s;
      ALU_SLL:   alu_s = fwd_rs1_s << op_b_s[4:0];
      ALU_SLT:   alu_s = {31'd0, $signed(fwd_rs1_s) < $signed(op_b_s)};
      ALU_SLTU:  alu_s = {31'd0, fwd_rs1_s < op_b_s};
      ALU_XOR:   alu_s = fwd_rs1_s ^ op_b_s;
      ALU_SRL:   alu_s = fwd_rs1_s >> op_b_s[4:0];
      ALU_SRA:   alu_s = $signed(fwd_rs1_s) >>> op_b_s[4:0];
      ALU_OR:    alu_s = fwd_rs1_s | op_b_s;
      ALU_AND:   alu_s = fwd_rs1_s & op_b_s;
      ALU_PASSB: alu_s = op_b_s;
      ALU_AUIPC: alu_s = bus.pc_in + bus.imm_in;
      default:   alu_s = 32'd0;
    endcase

    case (bus.bru_op)
      BRU_BEQ:  cond_s = (fwd_rs1_s == fwd_rs2_s);
      BRU_BNE:  cond_s = (fwd_rs1_s != fwd_rs2_s);
      BRU_JAL:  cond_s = 1'b1;
      BRU_JALR: cond_s = 1'b1;
      BRU_BLT:  cond_s = ($signed(fwd_rs1_s) < $signed(fwd_rs2_s));
      BRU_BGE:  cond_s = ($signed(fwd_rs1_s) >= $signed(fwd_rs2_s));
      BRU_BLTU: cond_s = (fwd_rs1_s < fwd_rs2_s);
      BRU_BGEU: cond_s = (fwd_rs1_s >= fwd_rs2_s);
      default:  cond_s = 1'b0;
    endcase

    is_link_s     = bus.branch & ((bus.bru_op == BRU_JAL) | (bus.bru_op == BRU_JALR));
    link_s        = bus.pc_in + 32'd4;
    target_s      = (bus.bru_op == BRU_JALR) ? ((fwd_rs1_s + bus.imm_in) & 32'hFFFF_FFFE)
                                             : (bus.pc_in + bus.imm_in);
    base_result_s = is_link_s ? link_s : alu_s;
  end

`ifdef EX_MULDIV_EN
  logic        md_start_s, md_busy_s, md_done_s;
  logic [31:0] md_result_s;

  assign md_start_s = rst & bus.md_en & ~bus.flush_in;

  muldiv_unit u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_s),
    .abort  (bus.flush_in),
    .op     (bus.md_op),
    .a      (fwd_rs1_s),
    .b      (fwd_rs2_s),
    .busy   (md_busy_s),
    .done   (md_done_s),
    .result (md_result_s)
  );

  // Stall covers the launch cycle in IDLE and every BUSY cycle; flush and reset drop it at once.
  assign stall_s  = rst & ~bus.flush_in & (md_busy_s | (bus.md_en & ~md_done_s));
  assign result_s = md_done_s ? md_result_s : base_result_s;
`else
  logic md_unused_s;

  assign md_unused_s = ^{clk, rst, bus.md_en, bus.md_op};
  assign stall_s     = 1'b0;
  assign result_s    = base_result_s;
`endif

  assign bus.alu_result    = result_s;
  assign bus.store_data    = fwd_rs2_s;
  assign bus.branch_taken  = bus.branch & cond_s;
  assign bus.flush_out     = bus.branch & cond_s;
  assign bus.branch_target = target_s;
  assign bus.stall_out     = stall_s;

endmodule
